// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if
//  Bundles the control inputs and status outputs of updown_mod_counter.
//  Signals:
//   clear, load, load_value, enable, up_down : controls toward the counter
//   count, terminal, wrap                    : status from the counter
//  Modports:
//   master : the controlling side (drives controls, observes status)
//   slave  : the counter itself
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             up_down;
    logic [WIDTH-1:0] count;
    logic             terminal;
    logic             wrap;

    modport master (
        output clear, load, load_value, enable, up_down,
        input  count, terminal, wrap
    );

    modport slave (
        input  clear, load, load_value, enable, up_down,
        output count, terminal, wrap
    );
endinterface

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//  Up/down modulo counter over 0..MODULUS-1 with wrap or saturate at the
//  range ends, parallel load (clamped into range) and synchronous clear.
//  Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears count and wrap
//   bus    : slave side of updown_mod_counter_if
//            clear > load > enable > hold, evaluated each rising edge
//            count    registered count value
//            terminal combinational end-of-range flag for current direction
//            wrap     registered one-cycle pulse after a wrapping step
module updown_mod_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    updown_mod_counter_if.slave  bus
);
    // Top of the count range; comparing against it (instead of relying on
    // natural overflow) makes MODULUS = 2**WIDTH behave as plain binary wrap.
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clear) begin
            count_d = '0;
        end else if (bus.load) begin
            // Out-of-range load values are clamped so count never leaves range.
            count_d = (bus.load_value > MAX_COUNT) ? MAX_COUNT : bus.load_value;
        end else if (bus.enable) begin
            if (bus.up_down) begin
                if (count_q == MAX_COUNT) begin
                    if (SATURATE == 0) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    if (SATURATE == 0) begin
                        count_d = MAX_COUNT;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.terminal = bus.up_down ? (count_q == MAX_COUNT) : (count_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter
//  Drives three counters (MODULUS=10 wrap, MODULUS=10 saturate, MODULUS=16
//  wrap, all WIDTH=4) and compares them against an arithmetic reference model.
module tb_updown_mod_counter;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(4)) m10w ();
    updown_mod_counter_if #(.WIDTH(4)) m10s ();
    updown_mod_counter_if #(.WIDTH(4)) m16w ();

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_m10w (
        .clk(clk), .reset(reset), .bus(m10w.slave));
    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_m10s (
        .clk(clk), .reset(reset), .bus(m10s.slave));
    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_m16w (
        .clk(clk), .reset(reset), .bus(m16w.slave));

    // Reference model: index 0 = m10w, 1 = m10s, 2 = m16w
    int mod_of [3] = '{10, 10, 16};
    bit sat_of [3] = '{1'b0, 1'b1, 1'b0};
    int m_count [3];
    bit m_wrap  [3];

    function automatic void model_next(int k, logic clr, logic ld, logic [3:0] lv,
                                       logic en, logic ud);
        int n;
        m_wrap[k] = 1'b0;
        if (clr) begin
            m_count[k] = 0;
        end else if (ld) begin
            m_count[k] = (int'(lv) > mod_of[k] - 1) ? mod_of[k] - 1 : int'(lv);
        end else if (en) begin
            n = m_count[k] + (ud ? 1 : -1);
            if (n < 0 || n >= mod_of[k]) begin
                if (!sat_of[k]) begin
                    m_count[k] = (n + mod_of[k]) % mod_of[k];
                    m_wrap[k]  = 1'b1;
                end
            end else begin
                m_count[k] = n;
            end
        end
    endfunction

    // Advance one clock: update the model from the current inputs, then
    // let the DUTs take the edge and settle.
    task automatic tick();
        model_next(0, m10w.clear, m10w.load, m10w.load_value, m10w.enable, m10w.up_down);
        model_next(1, m10s.clear, m10s.load, m10s.load_value, m10s.enable, m10s.up_down);
        model_next(2, m16w.clear, m16w.load, m16w.load_value, m16w.enable, m16w.up_down);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m10w.clear = 0; m10w.load = 0; m10w.load_value = 0; m10w.enable = 0; m10w.up_down = 1;
        m10s.clear = 0; m10s.load = 0; m10s.load_value = 0; m10s.enable = 0; m10s.up_down = 1;
        m16w.clear = 0; m16w.load = 0; m16w.load_value = 0; m16w.enable = 0; m16w.up_down = 1;
    endtask

    task automatic clear_all();
        idle_all();
        m10w.clear = 1; m10s.clear = 1; m16w.clear = 1;
        tick();
        idle_all();
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        n_tests++;
        if (m10w.count !== 4'd0 || m10w.wrap !== 1'b0 || m16w.count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_initial: count=%0d wrap=%0b required count=0 wrap=0",
                     m10w.count, m10w.wrap);
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin m_count[k] = 0; m_wrap[k] = 0; end
        // Reach count=7 on m10w while m16w wraps on the same edge.
        m10w.load = 1; m10w.load_value = 4'd6;
        m16w.load = 1; m16w.load_value = 4'd15;
        tick();
        idle_all();
        m10w.enable = 1; m16w.enable = 1;
        tick();
        idle_all();
        n_tests++;
        if (m10w.count !== 4'd7 || m16w.wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: count=%0d m16_wrap=%0b required count=7 m16_wrap=1",
                     m10w.count, m16w.wrap);
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (m10w.count !== 4'd0 || m10w.wrap !== 1'b0 || m16w.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: count=%0d wrap=%0b m16_wrap=%0b required 0 0 0",
                     m10w.count, m10w.wrap, m16w.wrap);
        end
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin m_count[k] = 0; m_wrap[k] = 0; end
        @(posedge clk); #1;
        $display("[TB] test_reset done");
    endtask

    task automatic test_wrap_up();
        int exp_c;
        clear_all();
        m10w.enable = 1; m10w.up_down = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_c = (i + 1) % 10;
            n_tests++;
            if (m10w.count !== 4'(exp_c) || m10w.wrap !== (i == 9) ||
                m10w.terminal !== (exp_c == 9)) begin
                n_fail++;
                $display("FAIL wrap_up step %0d: count=%0d wrap=%0b term=%0b required %0d %0b %0b",
                         i, m10w.count, m10w.wrap, m10w.terminal, exp_c, (i == 9), (exp_c == 9));
            end
        end
        idle_all();
        $display("[TB] test_wrap_up done");
    endtask

    task automatic test_down_and_saturate();
        clear_all();
        m10w.enable = 1; m10w.up_down = 0;
        tick();
        n_tests++;
        if (m10w.count !== 4'd9 || m10w.wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap: count=%0d wrap=%0b required 9 1", m10w.count, m10w.wrap);
        end
        idle_all();
        m10s.load = 1; m10s.load_value = 4'd9;
        tick();
        idle_all();
        m10s.enable = 1; m10s.up_down = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (m10s.count !== 4'd9 || m10s.wrap !== 1'b0 || m10s.terminal !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_up_hold: count=%0d wrap=%0b term=%0b required 9 0 1",
                         m10s.count, m10s.wrap, m10s.terminal);
            end
        end
        clear_all();
        m10s.enable = 1; m10s.up_down = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (m10s.count !== 4'd0 || m10s.wrap !== 1'b0 || m10s.terminal !== 1'b1) begin
                n_fail++;
                $display("FAIL sat_down_hold: count=%0d wrap=%0b term=%0b required 0 0 1",
                         m10s.count, m10s.wrap, m10s.terminal);
            end
        end
        idle_all();
        $display("[TB] test_down_and_saturate done");
    endtask

    task automatic test_load_clamp();
        clear_all();
        m10w.load = 1; m10w.load_value = 4'd13; m10w.enable = 1;
        m16w.load = 1; m16w.load_value = 4'd13; m16w.enable = 1;
        tick();
        n_tests++;
        if (m10w.count !== 4'd9 || m10w.wrap !== 1'b0 || m16w.count !== 4'd13) begin
            n_fail++;
            $display("FAIL load_clamp: m10=%0d wrap=%0b m16=%0d required 9 0 13",
                     m10w.count, m10w.wrap, m16w.count);
        end
        m10w.load_value = 4'd4;
        tick();
        n_tests++;
        if (m10w.count !== 4'd4) begin
            n_fail++;
            $display("FAIL load_value: count=%0d required 4", m10w.count);
        end
        idle_all();
        $display("[TB] test_load_clamp done");
    endtask

    task automatic test_clear_priority();
        m10w.load = 1; m10w.load_value = 4'd6;
        tick();
        m10w.clear = 1; m10w.load = 1; m10w.load_value = 4'd3; m10w.enable = 1;
        tick();
        n_tests++;
        if (m10w.count !== 4'd0 || m10w.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_priority: count=%0d wrap=%0b required 0 0", m10w.count, m10w.wrap);
        end
        idle_all();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (m10w.count !== 4'd0) begin
                n_fail++;
                $display("FAIL idle_hold: count=%0d required 0", m10w.count);
            end
        end
        $display("[TB] test_clear_priority done");
    endtask

    task automatic test_mod16();
        m16w.load = 1; m16w.load_value = 4'd15;
        tick();
        idle_all();
        m16w.enable = 1; m16w.up_down = 1;
        tick();
        n_tests++;
        if (m16w.count !== 4'd0 || m16w.wrap !== 1'b1) begin
            n_fail++;
            $display("FAIL mod16_wrap: count=%0d wrap=%0b required 0 1", m16w.count, m16w.wrap);
        end
        idle_all();
        m16w.load = 1; m16w.load_value = 4'd15;
        tick();
        idle_all();
        n_tests++;
        if (m16w.terminal !== 1'b1) begin
            n_fail++;
            $display("FAIL mod16_term_up: terminal=%0b required 1", m16w.terminal);
        end
        m16w.up_down = 0;
        #1;
        n_tests++;
        if (m16w.terminal !== 1'b0) begin
            n_fail++;
            $display("FAIL mod16_term_toggle: terminal=%0b required 0", m16w.terminal);
        end
        // Reversal at the top steps down without a wrap.
        m16w.enable = 1;
        tick();
        n_tests++;
        if (m16w.count !== 4'd14 || m16w.wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL mod16_reverse: count=%0d wrap=%0b required 14 0", m16w.count, m16w.wrap);
        end
        idle_all();
        $display("[TB] test_mod16 done");
    endtask

    task automatic test_random();
        logic [3:0] act_c [3];
        logic       act_w [3];
        logic       act_t [3];
        logic       ud    [3];
        int         exp_t;
        for (int i = 0; i < 400; i++) begin
            m10w.clear = ($urandom_range(0, 19) == 0); m10w.load = ($urandom_range(0, 9) == 0);
            m10w.load_value = 4'($urandom); m10w.enable = ($urandom_range(0, 3) != 0);
            m10w.up_down = ($urandom_range(0, 2) != 0);
            m10s.clear = ($urandom_range(0, 19) == 0); m10s.load = ($urandom_range(0, 9) == 0);
            m10s.load_value = 4'($urandom); m10s.enable = ($urandom_range(0, 3) != 0);
            m10s.up_down = ($urandom_range(0, 2) == 0);
            m16w.clear = ($urandom_range(0, 19) == 0); m16w.load = ($urandom_range(0, 9) == 0);
            m16w.load_value = 4'($urandom); m16w.enable = ($urandom_range(0, 3) != 0);
            m16w.up_down = $urandom_range(0, 1);
            tick();
            act_c = '{m10w.count, m10s.count, m16w.count};
            act_w = '{m10w.wrap, m10s.wrap, m16w.wrap};
            act_t = '{m10w.terminal, m10s.terminal, m16w.terminal};
            ud    = '{m10w.up_down, m10s.up_down, m16w.up_down};
            for (int k = 0; k < 3; k++) begin
                exp_t = ud[k] ? (m_count[k] == mod_of[k] - 1) : (m_count[k] == 0);
                n_tests++;
                if (act_c[k] !== 4'(m_count[k]) || act_w[k] !== m_wrap[k] ||
                    act_t[k] !== 1'(exp_t)) begin
                    n_fail++;
                    $display("FAIL random cyc %0d dut %0d: count=%0d wrap=%0b term=%0b required %0d %0b %0b",
                             i, k, act_c[k], act_w[k], act_t[k], m_count[k], m_wrap[k], exp_t);
                end
            end
        end
        idle_all();
        $display("[TB] test_random done");
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_and_saturate();
        test_load_clamp();
        test_clear_priority();
        test_mod16();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
